// File: rtl/axi_manager_ctrl_if.sv
// Bundle for the manager's local command/response port and its AXI-style
// AW/W/B/AR/R channels. "master" is the manager's view, "slave" is the
// view of whatever sits around it (command source plus subordinate).
interface axi_manager_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWDATA;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BDATA;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARDATA;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           AWREADY, WREADY, BVALID, BDATA, ARREADY, RVALID, RDATA, RRESP,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           AWVALID, AWDATA, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARDATA, RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           AWREADY, WREADY, BVALID, BDATA, ARREADY, RVALID, RDATA, RRESP,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
           AWVALID, AWDATA, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARDATA, RREADY
  );
endinterface

// File: rtl/axi_manager_ctrl.sv
// Single-outstanding AXI manager. Takes one read or write command from the
// local command port, runs it over AW/W/B or AR/R, hands the result back on
// the response port and keeps a saturating count of non-OKAY responses.
module axi_manager_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_manager_ctrl_if.master  bus,
  output logic [ERRCNT_W-1:0] err_count
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} resp_t;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  state_t              state_q, state_d;
  logic                awDone_q, awDone_d;
  logic                wDone_q, wDone_d;
  logic                bready_q, bready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                rspWrite_q, rspWrite_d;
  logic [DATA_W-1:0]   rspRdata_q, rspRdata_d;
  logic [1:0]          rspResp_q, rspResp_d;
  logic [ERRCNT_W-1:0] errCount_q, errCount_d;
  logic                awHs, wHs, capture;
  logic [1:0]          captureResp;

  // Latched command fields drive the bus data lines, so they stay stable
  // for as long as the matching VALID is up.
  assign bus.AWDATA    = addr_q;
  assign bus.ARDATA    = addr_q;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.rsp_write = rspWrite_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_resp  = rspResp_q;
  assign err_count     = errCount_q;

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      bready_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rspWrite_q <= 1'b0;
      rspRdata_q <= '0;
      rspResp_q  <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      awDone_q   <= awDone_d;
      wDone_q    <= wDone_d;
      bready_q   <= bready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rspWrite_q <= rspWrite_d;
      rspRdata_q <= rspRdata_d;
      rspResp_q  <= rspResp_d;
      errCount_q <= errCount_d;
    end
  end

  // Next-state and handshake outputs. BREADY comes from a flop that rises a
  // cycle into WR_RESP so it never follows the AW/W handshakes combinationally;
  // this is what makes a write one cycle longer than a read.
  always_comb begin
    state_d     = state_q;
    awDone_d    = awDone_q;
    wDone_d     = wDone_q;
    bready_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rspWrite_d  = rspWrite_q;
    rspRdata_d  = rspRdata_q;
    rspResp_d   = rspResp_q;
    errCount_d  = errCount_q;
    awHs        = 1'b0;
    wHs         = 1'b0;
    capture     = 1'b0;
    captureResp = OKAY;

    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.AWVALID   = 1'b0;
    bus.WVALID    = 1'b0;
    bus.BREADY    = 1'b0;
    bus.ARVALID   = 1'b0;
    bus.RREADY    = 1'b0;

    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        awDone_d      = 1'b0;
        wDone_d       = 1'b0;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          state_d = bus.cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        bus.AWVALID = !awDone_q;
        bus.WVALID  = !wDone_q;
        awHs        = !awDone_q && bus.AWREADY;
        wHs         = !wDone_q && bus.WREADY;
        if (awHs) awDone_d = 1'b1;
        if (wHs)  wDone_d  = 1'b1;
        if ((awDone_q || awHs) && (wDone_q || wHs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bus.BREADY = bready_q;
        bready_d   = 1'b1;
        if (bready_q && bus.BVALID) begin
          bready_d    = 1'b0;
          capture     = 1'b1;
          captureResp = bus.BDATA;
          rspResp_d   = bus.BDATA;
          rspWrite_d  = 1'b1;
          rspRdata_d  = '0;
          state_d     = RESP;
        end
      end
      RD_ADDR: begin
        bus.ARVALID = 1'b1;
        if (bus.ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        bus.RREADY = 1'b1;
        if (bus.RVALID) begin
          capture     = 1'b1;
          captureResp = bus.RRESP;
          rspResp_d   = bus.RRESP;
          rspWrite_d  = 1'b0;
          rspRdata_d  = bus.RDATA;
          state_d     = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture && (captureResp != OKAY) && (errCount_q != {ERRCNT_W{1'b1}}))
      errCount_d = errCount_q + ERRCNT_W'(1);
  end
endmodule

// File: tb/tb_axi_manager_ctrl.sv
// Directed bench for axi_manager_ctrl. A second instance with a 2-bit error
// counter runs in lockstep on the same stimulus to exercise saturation.
module tb_axi_manager_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic       ACLK;
  logic       ARESET;
  logic [7:0] errCount;
  logic [1:0] errCountSmall;
  int         checkCount = 0;
  int         passCount  = 0;
  int         failCount  = 0;
  logic [1:0] smallExp [5];

  axi_manager_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  axi_manager_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busSmall();

  axi_manager_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus.master), .err_count(errCount)
  );

  axi_manager_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(2)) dutSmall (
    .ACLK(ACLK), .ARESET(ARESET), .bus(busSmall.master), .err_count(errCountSmall)
  );

  assign busSmall.cmd_valid = bus.cmd_valid;
  assign busSmall.cmd_write = bus.cmd_write;
  assign busSmall.cmd_addr  = bus.cmd_addr;
  assign busSmall.cmd_wdata = bus.cmd_wdata;
  assign busSmall.cmd_wstrb = bus.cmd_wstrb;
  assign busSmall.rsp_ready = bus.rsp_ready;
  assign busSmall.AWREADY   = bus.AWREADY;
  assign busSmall.WREADY    = bus.WREADY;
  assign busSmall.BVALID    = bus.BVALID;
  assign busSmall.BDATA     = bus.BDATA;
  assign busSmall.ARREADY   = bus.ARREADY;
  assign busSmall.RVALID    = bus.RVALID;
  assign busSmall.RDATA     = bus.RDATA;
  assign busSmall.RRESP     = bus.RRESP;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance one cycle; everything is sampled and driven 1 ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               input logic [3:0] wstrb);
    bus.cmd_valid = valid;
    bus.cmd_write = write;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    smallExp[0] = 2'd1; smallExp[1] = 2'd2; smallExp[2] = 2'd3;
    smallExp[3] = 2'd3; smallExp[4] = 2'd3;

    // Reset with every input idle
    ARESET = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    bus.rsp_ready = 1'b0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BDATA = 2'd0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'd0;
    tick();
    tick();
    checkOutput("rst cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst awvalid", bus.AWVALID, 0);
    checkOutput("rst wvalid", bus.WVALID, 0);
    checkOutput("rst bready", bus.BREADY, 0);
    checkOutput("rst arvalid", bus.ARVALID, 0);
    checkOutput("rst rready", bus.RREADY, 0);
    checkOutput("rst rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst awdata", bus.AWDATA, 0);
    checkOutput("rst rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("rst err_count", errCount, 0);
    ARESET = 1'b0;

    // Write 0x0A4 with everything ready: valids up one cycle, rsp at cycle 4
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1; bus.BVALID = 1'b1; bus.BDATA = 2'd0;
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 12'h0A4, 32'hDEADBEEF, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    checkOutput("w1 awvalid c1", bus.AWVALID, 1);
    checkOutput("w1 wvalid c1", bus.WVALID, 1);
    checkOutput("w1 awdata", bus.AWDATA, 12'h0A4);
    checkOutput("w1 wdata", bus.WDATA, 32'hDEADBEEF);
    checkOutput("w1 wstrb", bus.WSTRB, 4'hF);
    checkOutput("w1 cmd_ready busy", bus.cmd_ready, 0);
    tick();
    checkOutput("w1 awvalid c2", bus.AWVALID, 0);
    checkOutput("w1 wvalid c2", bus.WVALID, 0);
    checkOutput("w1 rsp_valid c2", bus.rsp_valid, 0);
    tick();
    checkOutput("w1 bready c3", bus.BREADY, 1);
    checkOutput("w1 rsp_valid c3", bus.rsp_valid, 0);
    tick();
    checkOutput("w1 rsp_valid c4", bus.rsp_valid, 1);
    checkOutput("w1 rsp_write", bus.rsp_write, 1);
    checkOutput("w1 rsp_resp", bus.rsp_resp, 0);
    checkOutput("w1 rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("w1 err_count", errCount, 0);
    checkOutput("w1 bready in resp", bus.BREADY, 0);
    tick();
    checkOutput("w1 rsp_valid drop", bus.rsp_valid, 0);
    checkOutput("w1 cmd_ready idle", bus.cmd_ready, 1);
    checkOutput("w1 bvalid ignored", bus.BREADY, 0);

    // Write with AWREADY held off for 5 cycles, WREADY immediate
    bus.AWREADY = 1'b0; bus.WREADY = 1'b1; bus.BVALID = 1'b0;
    applyStimulus(1'b1, 1'b1, 12'h3F0, 32'hCAFEF00D, 4'h3);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    checkOutput("w2 wstrb", bus.WSTRB, 4'h3);
    for (int i = 1; i <= 5; i++) begin
      checkOutput("w2 awvalid held", bus.AWVALID, 1);
      checkOutput("w2 awdata stable", bus.AWDATA, 12'h3F0);
      checkOutput("w2 wvalid", bus.WVALID, (i == 1) ? 64'd1 : 64'd0);
      checkOutput("w2 bready early", bus.BREADY, 0);
      if (i == 5) bus.AWREADY = 1'b1;
      tick();
    end
    bus.AWREADY = 1'b0;
    checkOutput("w2 awvalid drop", bus.AWVALID, 0);
    checkOutput("w2 bready c6", bus.BREADY, 0);
    tick();
    checkOutput("w2 bready c7", bus.BREADY, 1);
    bus.BVALID = 1'b1; bus.BDATA = 2'd0;
    tick();
    bus.BVALID = 1'b0;
    checkOutput("w2 rsp_valid", bus.rsp_valid, 1);
    checkOutput("w2 rsp_write", bus.rsp_write, 1);
    checkOutput("w2 rsp_resp", bus.rsp_resp, 0);
    tick();
    checkOutput("w2 idle", bus.cmd_ready, 1);

    // Read 0x010 returning SLVERR, consumer stalls for 3 cycles
    bus.rsp_ready = 1'b0;
    bus.ARREADY = 1'b1; bus.RVALID = 1'b1; bus.RDATA = 32'h12345678; bus.RRESP = 2'd2;
    applyStimulus(1'b1, 1'b0, 12'h010, '0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    checkOutput("r1 arvalid", bus.ARVALID, 1);
    checkOutput("r1 ardata", bus.ARDATA, 12'h010);
    checkOutput("r1 rready c1", bus.RREADY, 0);
    tick();
    checkOutput("r1 arvalid drop", bus.ARVALID, 0);
    checkOutput("r1 rready c2", bus.RREADY, 1);
    tick();
    bus.RVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("r1 rsp_valid hold", bus.rsp_valid, 1);
      checkOutput("r1 rsp_rdata", bus.rsp_rdata, 32'h12345678);
      checkOutput("r1 rsp_resp", bus.rsp_resp, 2);
      checkOutput("r1 rsp_write", bus.rsp_write, 0);
      checkOutput("r1 cmd_ready busy", bus.cmd_ready, 0);
      checkOutput("r1 err_count", errCount, 1);
      tick();
    end
    checkOutput("r1 rsp_valid c6", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("r1 rsp_valid drop", bus.rsp_valid, 0);
    checkOutput("r1 cmd_ready idle", bus.cmd_ready, 1);

    // Error counter saturation: reset, then 5 DECERR reads
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checkOutput("sat err reset", errCount, 0);
    checkOutput("sat small reset", errCountSmall, 0);
    bus.RVALID = 1'b1; bus.RRESP = 2'd3;
    for (int k = 0; k < 5; k++) begin
      bus.RDATA = 32'hF000_0000 + k;
      applyStimulus(1'b1, 1'b0, 12'h200 + 12'(k), '0, 4'h0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
      tick();
      tick();
      checkOutput("sat rsp_resp", bus.rsp_resp, 3);
      checkOutput("sat rsp_rdata", bus.rsp_rdata, 32'hF000_0000 + k);
      checkOutput("sat err 8bit", errCount, k + 1);
      checkOutput("sat err 2bit", errCountSmall, smallExp[k]);
      tick();
    end
    bus.RVALID = 1'b0; bus.RRESP = 2'd0;

    // Reset while waiting in WR_RESP with BVALID low
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1; bus.BVALID = 1'b0;
    applyStimulus(1'b1, 1'b1, 12'h0C0, 32'h0BADF00D, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    tick();
    tick();
    checkOutput("rw bready waiting", bus.BREADY, 1);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    checkOutput("rw awvalid", bus.AWVALID, 0);
    checkOutput("rw wvalid", bus.WVALID, 0);
    checkOutput("rw bready", bus.BREADY, 0);
    checkOutput("rw arvalid", bus.ARVALID, 0);
    checkOutput("rw rready", bus.RREADY, 0);
    checkOutput("rw cmd_ready", bus.cmd_ready, 1);
    checkOutput("rw rsp_valid", bus.rsp_valid, 0);
    checkOutput("rw err_count", errCount, 0);
    bus.ARREADY = 1'b1; bus.RVALID = 1'b1; bus.RDATA = 32'hA5A50F0F; bus.RRESP = 2'd0;
    applyStimulus(1'b1, 1'b0, 12'h055, '0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    checkOutput("rw read ardata", bus.ARDATA, 12'h055);
    tick();
    tick();
    checkOutput("rw read rsp_valid", bus.rsp_valid, 1);
    checkOutput("rw read rdata", bus.rsp_rdata, 32'hA5A50F0F);
    checkOutput("rw read write", bus.rsp_write, 0);
    checkOutput("rw read resp", bus.rsp_resp, 0);
    tick();

    // Back-to-back reads with cmd_valid held high
    bus.RDATA = 32'h11111111; bus.RRESP = 2'd0;
    applyStimulus(1'b1, 1'b0, 12'h100, '0, 4'h0);
    tick();
    checkOutput("bb arvalid 1", bus.ARVALID, 1);
    checkOutput("bb ardata 1", bus.ARDATA, 12'h100);
    applyStimulus(1'b1, 1'b0, 12'h200, '0, 4'h0);
    tick();
    checkOutput("bb ardata held", bus.ARDATA, 12'h100);
    tick();
    checkOutput("bb rsp_valid 1", bus.rsp_valid, 1);
    checkOutput("bb rdata 1", bus.rsp_rdata, 32'h11111111);
    checkOutput("bb arvalid in resp", bus.ARVALID, 0);
    bus.RDATA = 32'h22222222; bus.RRESP = 2'd1;
    tick();
    checkOutput("bb rsp_valid drop", bus.rsp_valid, 0);
    checkOutput("bb arvalid +1", bus.ARVALID, 0);
    checkOutput("bb cmd_ready", bus.cmd_ready, 1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 4'h0);
    checkOutput("bb arvalid 2", bus.ARVALID, 1);
    checkOutput("bb ardata 2", bus.ARDATA, 12'h200);
    tick();
    tick();
    checkOutput("bb rsp_valid 2", bus.rsp_valid, 1);
    checkOutput("bb rdata 2", bus.rsp_rdata, 32'h22222222);
    checkOutput("bb resp 2", bus.rsp_resp, 1);
    checkOutput("bb exokay counted", errCount, 1);
    tick();
    bus.RVALID = 1'b0;
    checkOutput("bb final idle", bus.cmd_ready, 1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/axi_manager_ctrl.md
Name: axi_manager_ctrl

Overview:
- Single-outstanding AXI manager (initiator). It is the requesting end of the bus whose subordinate side our RX/TX channel wrappers implement.
- Accepts one read or write command at a time from a local command port (testbench or CPU model) and drives the AW/W/B or AR/R channels. Returns the response on a local response port.
- Keeps a saturating count of non-OKAY responses for status and debug.

Parameters:
- ADDR_W, 12, address width on the command port and on AWDATA/ARDATA.
- DATA_W, 32, data width on the command port and on WDATA/RDATA. Must be a multiple of 8.
- ERRCNT_W, 8, width of the error counter.

Ports:
- ACLK  in  1  bus clock; all logic is rising-edge.
- ARESET  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_write  out  1  echoes cmd_write of the completed transfer.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  resp_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
- err_count  out  ERRCNT_W  saturating count of non-OKAY responses.
- AWVALID  out  1  write address valid.
- AWREADY  in  1  write address ready.
- AWDATA  out  ADDR_W  write address.
- WVALID  out  1  write data valid.
- WREADY  in  1  write data ready.
- WDATA  out  DATA_W  write data.
- WSTRB  out  DATA_W/8  write strobes.
- BVALID  in  1  write response valid.
- BREADY  out  1  write response ready.
- BDATA  in  2  write response.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- ARDATA  out  ADDR_W  read address.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- RDATA  in  DATA_W  read data.
- RRESP  in  2  read response.

Behaviour:
- Reset (ARESET sampled high at an ACLK edge):
  - State goes to IDLE.
  - All VALID/READY outputs and rsp_valid go to 0.
  - cmd_ready goes to 1.
  - All data outputs, rsp_* and err_count go to 0.
  - An in-flight transfer is abandoned with no response.
- Handshake: a transfer occurs on any edge where VALID and READY are both 1.
- States:
  - IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_*.
  - Go to WR_ADDR_DATA if cmd_write=1, else RD_ADDR.
  - cmd_ready=0 in every other state.
- WR_ADDR_DATA:
  - AWVALID and WVALID both rise the cycle after acceptance (1-cycle latency).
  - Each VALID drops independently on the edge after its own handshake.
  - AWDATA/WDATA/WSTRB are held stable while their VALID is 1.
  - AW-before-W, W-before-AW and simultaneous handshakes are all legal.
  - Go to WR_RESP on the edge where the last of the two handshakes completes.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BDATA into rsp_resp, set rsp_write=1 and rsp_rdata=0, then go to RESP.
  - BVALID outside WR_RESP is ignored (BREADY=0).
- RD_ADDR:
  - ARVALID=1 with ARDATA held.
  - On handshake, go to RD_DATA; ARVALID drops.
- RD_DATA:
  - RREADY=1.
  - On RVALID, capture RDATA and RRESP, set rsp_write=0, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_* stable until rsp_ready.
  - On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - A new command is accepted no earlier than the cycle after return to IDLE.
- Minimum write: 4 cycles from acceptance to rsp_valid, with READY/VALID tied high. Minimum read: 3 cycles.
- err_count:
  - Increments by 1 on the B or R capture edge when the response is not OKAY.
  - Holds at 2^ERRCNT_W−1 (saturates, no wrap).
  - Counts every non-OKAY response; EXOKAY also counts.
- Subordinate READY may be held low indefinitely; the block waits with no timeout, and VALID is never withdrawn before its handshake.

Test Plan:
- Write 0x0A4, data 0xDEADBEEF, strobe 0xF, subordinate always ready, BDATA=OKAY -> AWVALID and WVALID high for exactly 1 cycle; rsp_valid 4 cycles after acceptance with rsp_write=1, rsp_resp=0; err_count stays 0.
- Write with AWREADY delayed 5 cycles and WREADY immediate -> WVALID drops after 1 cycle; AWVALID stays high for 5 cycles with AWDATA stable; BREADY rises only after the AW handshake.
- Read 0x010, RDATA=0x12345678, RRESP=SLVERR, rsp_ready held low for 3 cycles -> rsp_rdata=0x12345678 and rsp_resp=2 held for 3 cycles; err_count=1; cmd_ready=0 until return to IDLE.
- ERRCNT_W=2: 5 reads with DECERR -> err_count reads 1, 2, 3, 3, 3.
- ARESET asserted in WR_RESP with BVALID low -> next edge: all VALID/READY=0, cmd_ready=1, no rsp_valid; a following read completes normally.
- Back-to-back: cmd_valid held high for 2 reads with rsp_ready=1 -> second ARVALID appears no earlier than 2 cycles after the first rsp_valid; both responses are correct and in order.
